alu_pwr_seq: RTL and testbench

// Power-gating sequencer directly upstream of the ALU top-level. It generates the
// alu_pwr_en and iso_en controls the top-level consumes, and gates the ALU start strobe.

---
 rtl/alu_pwr_if.sv | 27 ++
 rtl/alu_pwr_seq.sv | 158 +++++++++++++++
 tb/tb_alu_pwr_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pwr_if.sv
// ALU power-sequencer control bundle.
// Groups the sleep/wake requests, the start handshake and the power/isolation
// controls that pass between the issuing logic, the sequencer and the ALU top.
//   master : issuing side (drives requests, start_i, alu_busy; observes status)
//   slave  : sequencer side (alu_pwr_seq)
interface alu_pwr_if;
  logic       sleep_req;
  logic       wake_req;
  logic       start_i;
  logic       alu_busy;
  logic       start_o;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       alu_ready;
  logic       start_drop;
  logic [2:0] pwr_state;

  modport master (
    output sleep_req, wake_req, start_i, alu_busy,
    input  start_o, alu_pwr_en, iso_en, alu_ready, start_drop, pwr_state
  );

  modport slave (
    input  sleep_req, wake_req, start_i, alu_busy,
    output start_o, alu_pwr_en, iso_en, alu_ready, start_drop, pwr_state
  );
endinterface

// File: rtl/alu_pwr_seq.sv
// Power-gating sequencer for the ALU.
// Orders sleep as drain -> isolate -> power off and wake as power on -> ramp ->
// release isolation, so iso_en is high whenever the ALU is unpowered or its
// supply is switching. Also gates the ALU start strobe, auto-sleeps after an
// idle period and auto-wakes when a start arrives while powered down.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : alu_pwr_if.slave
//          in  sleep_req, wake_req, start_i, alu_busy
//          out start_o, alu_pwr_en, iso_en, alu_ready, start_drop, pwr_state
//
// state    | meaning
// ON       | powered, isolation off, starts forwarded, idle timer running
// DRAIN    | sleep accepted, waiting for alu_busy to fall
// ISO      | isolation on, power still on, ISO_SETUP cycles
// OFF      | power off, isolation on, waiting for wake_req / wake_pend
// RAMP     | power on, isolation on, PWR_UP_DLY settle cycles
// RELEASE  | power on, isolation on, ISO_RELEASE extra cycles
module alu_pwr_seq #(
  parameter int unsigned ISO_SETUP   = 2,
  parameter int unsigned PWR_UP_DLY  = 8,
  parameter int unsigned ISO_RELEASE = 2,
  parameter int unsigned IDLE_TMO    = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_pwr_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ISO     = 3'd2,
    ST_OFF     = 3'd3,
    ST_RAMP    = 3'd4,
    ST_RELEASE = 3'd5
  } pwr_state_t;

  // Timed states end when the up-counter hits the last index; a zero delay
  // still lasts one cycle because the last index is clamped to 0.
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] ISO_LAST = (ISO_SETUP   == 0) ? '0 : CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] PWR_LAST = (PWR_UP_DLY  == 0) ? '0 : CNT_W'(PWR_UP_DLY - 1);
  localparam logic [CNT_W-1:0] REL_LAST = (ISO_RELEASE == 0) ? '0 : CNT_W'(ISO_RELEASE - 1);
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_TMO);
  localparam bit               IDLE_EN  = (IDLE_TMO != 0);

  pwr_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             wake_pend, wake_pend_nxt;
  logic             start_o_q, start_drop_q, pwr_en_q, iso_en_q, ready_q;
  logic             active;

  assign active = bus.start_i | bus.alu_busy;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wake_pend_nxt = wake_pend;
    cnt_inc       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // A start that cannot be served now still asks for the ALU to come up.
    if (state != ST_ON && bus.start_i)
      wake_pend_nxt = 1'b1;

    unique case (state)
      ST_ON: begin
        cnt_nxt = active ? '0 : cnt_inc;
        if (bus.sleep_req || (IDLE_EN && !active && cnt_inc == IDLE_LIM)) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        if (bus.wake_req)
          wake_pend_nxt = 1'b1;
        if (!bus.alu_busy) begin
          state_nxt = ST_ISO;
          cnt_nxt   = '0;
        end
      end
      ST_ISO: begin
        if (bus.wake_req)
          wake_pend_nxt = 1'b1;
        if (cnt == ISO_LAST) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_OFF: begin
        // This wake serves any pending start, so the pending flag is consumed.
        if (bus.wake_req || wake_pend) begin
          state_nxt     = ST_RAMP;
          cnt_nxt       = '0;
          wake_pend_nxt = 1'b0;
        end
      end
      ST_RAMP: begin
        if (bus.wake_req)
          wake_pend_nxt = 1'b1;
        if (cnt == PWR_LAST) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_RELEASE: begin
        if (cnt == REL_LAST) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register; iso stays high in every state except ON and DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_OFF;
      cnt          <= '0;
      wake_pend    <= 1'b0;
      start_o_q    <= 1'b0;
      start_drop_q <= 1'b0;
      pwr_en_q     <= 1'b0;
      iso_en_q     <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      wake_pend    <= wake_pend_nxt;
      start_o_q    <= (state == ST_ON) && bus.start_i;
      start_drop_q <= (state != ST_ON) && bus.start_i;
      pwr_en_q     <= (state_nxt != ST_OFF);
      iso_en_q     <= !((state_nxt == ST_ON) || (state_nxt == ST_DRAIN));
      ready_q      <= (state_nxt == ST_ON);
    end
  end

  assign bus.start_o    = start_o_q;
  assign bus.start_drop = start_drop_q;
  assign bus.alu_pwr_en = pwr_en_q;
  assign bus.iso_en     = iso_en_q;
  assign bus.alu_ready  = ready_q;
  assign bus.pwr_state  = state;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Self-checking bench for alu_pwr_seq: directed scenarios with fixed expected
// timing, then a random run compared cycle by cycle against a phase model.
module tb_alu_pwr_seq;
  localparam int ISO_SETUP   = 2;
  localparam int PWR_UP_DLY  = 8;
  localparam int ISO_RELEASE = 2;
  localparam int IDLE_TMO    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_pwr_if bus ();

  alu_pwr_seq #(
    .ISO_SETUP(ISO_SETUP), .PWR_UP_DLY(PWR_UP_DLY), .ISO_RELEASE(ISO_RELEASE),
    .IDLE_TMO(IDLE_TMO), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase number (spec encoding), cycles left in a timed
  // phase, idle cycles seen in ON, pending-wake flag, last strobes.
  int m_ph, m_left, m_idle;
  bit m_pend, m_so, m_drop;
  bit pwr_tab[6]   = '{1, 1, 1, 0, 1, 1};
  bit iso_tab[6]   = '{0, 0, 1, 1, 1, 1};
  bit ready_tab[6] = '{1, 0, 0, 0, 0, 0};
  int dur_tab[6]   = '{0, 0, ISO_SETUP, 0, PWR_UP_DLY, ISO_RELEASE};

  function automatic void model_reset();
    m_ph = 3; m_left = 0; m_idle = 0; m_pend = 0; m_so = 0; m_drop = 0;
  endfunction

  function automatic void model_edge(input bit s, input bit w, input bit st, input bit b);
    int nph   = m_ph;
    bit npend = m_pend;
    m_so   = (m_ph == 0) && st;
    m_drop = (m_ph != 0) && st;
    if (m_ph != 0 && st) npend = 1;
    if (w && (m_ph == 1 || m_ph == 2 || m_ph == 4)) npend = 1;
    case (m_ph)
      0: begin
        m_idle = (st || b) ? 0 : m_idle + 1;
        if (s || (IDLE_TMO != 0 && m_idle == IDLE_TMO)) nph = 1;
      end
      1: if (!b) nph = 2;
      3: if (w || m_pend) begin nph = 4; npend = 0; end
      default: begin
        m_left--;
        if (m_left <= 0) nph = (m_ph == 5) ? 0 : m_ph + 1;
      end
    endcase
    if (nph != m_ph) begin
      m_left = (dur_tab[nph] < 1) ? 1 : dur_tab[nph];
      m_idle = 0;
    end
    m_ph   = nph;
    m_pend = npend;
  endfunction

  task automatic cyc(input bit s, input bit w, input bit st, input bit b);
    rst = 1'b0;
    bus.sleep_req = s; bus.wake_req = w; bus.start_i = st; bus.alu_busy = b;
    @(posedge clk); #1;
    model_edge(s, w, st, b);
  endtask

  task automatic rst_cyc();
    rst = 1'b1;
    bus.sleep_req = 0; bus.wake_req = 0; bus.start_i = 0; bus.alu_busy = 0;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst_cyc(); rst_cyc();
    checks++; if (bus.pwr_state !== 3'd3) begin errors++; $display("FAIL reset_state: got %0d expected 3", bus.pwr_state); end
    checks++; if (bus.alu_pwr_en !== 1'b0) begin errors++; $display("FAIL reset_pwr: got %0b expected 0", bus.alu_pwr_en); end
    checks++; if (bus.iso_en !== 1'b1) begin errors++; $display("FAIL reset_iso: got %0b expected 1", bus.iso_en); end
    checks++; if ({bus.alu_ready, bus.start_o, bus.start_drop} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {bus.alu_ready, bus.start_o, bus.start_drop}); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pwr_state !== 3'd3) begin errors++; $display("FAIL reset_hold_off: got %0d expected 3", bus.pwr_state); end
  endtask

  task automatic test_wake();
    cyc(0, 1, 0, 0);
    checks++; if ({bus.alu_pwr_en, bus.iso_en, bus.pwr_state} !== {1'b1, 1'b1, 3'd4}) begin
      errors++; $display("FAIL wake_ramp: got pwr=%0b iso=%0b st=%0d expected 1 1 4", bus.alu_pwr_en, bus.iso_en, bus.pwr_state); end
    for (int i = 2; i <= 10; i++) begin
      cyc(0, 0, 0, 0);
      checks++; if (bus.iso_en !== 1'b1 || bus.alu_ready !== 1'b0) begin
        errors++; $display("FAIL wake_iso_hold c%0d: got iso=%0b ready=%0b expected 1 0", i, bus.iso_en, bus.alu_ready); end
    end
    cyc(0, 0, 0, 0);
    checks++; if ({bus.alu_ready, bus.iso_en, bus.pwr_state} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL wake_ready_c11: got ready=%0b iso=%0b st=%0d expected 1 0 0", bus.alu_ready, bus.iso_en, bus.pwr_state); end
  endtask

  task automatic test_sleep_drain();
    cyc(1, 0, 1, 1);
    checks++; if (bus.start_o !== 1'b1) begin errors++; $display("FAIL sleep_start_fwd: got %0b expected 1", bus.start_o); end
    checks++; if ({bus.pwr_state, bus.alu_ready, bus.alu_pwr_en, bus.iso_en} !== {3'd1, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sleep_drain_entry: got st=%0d ready=%0b pwr=%0b iso=%0b expected 1 0 1 0",
                         bus.pwr_state, bus.alu_ready, bus.alu_pwr_en, bus.iso_en); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      checks++; if (bus.pwr_state !== 3'd1 || bus.start_o !== 1'b0) begin
        errors++; $display("FAIL sleep_drain_hold %0d: got st=%0d start_o=%0b expected 1 0", i, bus.pwr_state, bus.start_o); end
    end
    cyc(0, 0, 0, 0);
    checks++; if ({bus.pwr_state, bus.alu_pwr_en, bus.iso_en} !== {3'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sleep_iso1: got st=%0d pwr=%0b iso=%0b expected 2 1 1", bus.pwr_state, bus.alu_pwr_en, bus.iso_en); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pwr_state !== 3'd2) begin errors++; $display("FAIL sleep_iso2: got %0d expected 2", bus.pwr_state); end
    cyc(0, 0, 0, 0);
    checks++; if ({bus.pwr_state, bus.alu_pwr_en, bus.iso_en} !== {3'd3, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sleep_off: got st=%0d pwr=%0b iso=%0b expected 3 0 1", bus.pwr_state, bus.alu_pwr_en, bus.iso_en); end
  endtask

  task automatic test_idle();
    int n = 0;
    cyc(0, 1, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL idle_on: got ready=%0b expected 1", bus.alu_ready); end
    while (bus.pwr_state === 3'd0 && n < 300) begin cyc(0, 0, 0, 0); n++; end
    checks++; if (n != IDLE_TMO || bus.pwr_state !== 3'd1) begin
      errors++; $display("FAIL idle_timeout: got %0d ON cycles st=%0d expected %0d then 1", n, bus.pwr_state, IDLE_TMO); end
    repeat (1 + ISO_SETUP) cyc(0, 0, 0, 0);
    checks++; if (bus.pwr_state !== 3'd3 || bus.alu_pwr_en !== 1'b0) begin
      errors++; $display("FAIL idle_off: got st=%0d pwr=%0b expected 3 0", bus.pwr_state, bus.alu_pwr_en); end
  endtask

  task automatic test_off_start();
    int n = 0;
    cyc(0, 0, 1, 0);
    checks++; if ({bus.start_drop, bus.start_o, bus.pwr_state} !== {1'b1, 1'b0, 3'd3}) begin
      errors++; $display("FAIL off_start_drop: got drop=%0b start_o=%0b st=%0d expected 1 0 3", bus.start_drop, bus.start_o, bus.pwr_state); end
    // wake_pend is visible from this cycle; ready follows 1+PWR_UP_DLY+ISO_RELEASE cycles later
    cyc(0, 0, 0, 0);
    checks++; if (bus.start_drop !== 1'b0 || bus.pwr_state !== 3'd4) begin
      errors++; $display("FAIL off_autowake: got drop=%0b st=%0d expected 0 4", bus.start_drop, bus.pwr_state); end
    while (bus.alu_ready !== 1'b1 && n < 50) begin cyc(0, 0, 0, 0); n++; end
    checks++; if (n != PWR_UP_DLY + ISO_RELEASE) begin
      errors++; $display("FAIL off_autowake_latency: got %0d expected %0d", n, PWR_UP_DLY + ISO_RELEASE); end
  endtask

  task automatic test_wake_iso();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (bus.pwr_state !== 3'd2) begin errors++; $display("FAIL wiso_in_iso: got %0d expected 2", bus.pwr_state); end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (bus.pwr_state !== 3'd3 || bus.alu_pwr_en !== 1'b0) begin
      errors++; $display("FAIL wiso_off: got st=%0d pwr=%0b expected 3 0", bus.pwr_state, bus.alu_pwr_en); end
    cyc(0, 0, 0, 0);
    checks++; if ({bus.pwr_state, bus.alu_pwr_en, bus.iso_en} !== {3'd4, 1'b1, 1'b1}) begin
      errors++; $display("FAIL wiso_rewake: got st=%0d pwr=%0b iso=%0b expected 4 1 1", bus.pwr_state, bus.alu_pwr_en, bus.iso_en); end
    repeat (PWR_UP_DLY + ISO_RELEASE) cyc(0, 0, 0, 0);
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL wiso_on: got ready=%0b expected 1", bus.alu_ready); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    checks++; if (bus.pwr_state !== 3'd1) begin errors++; $display("FAIL rmid_drain: got %0d expected 1", bus.pwr_state); end
    rst_cyc();
    checks++; if ({bus.pwr_state, bus.alu_pwr_en, bus.iso_en, bus.alu_ready} !== {3'd3, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rmid_drain_rst: got st=%0d pwr=%0b iso=%0b ready=%0b expected 3 0 1 0",
                         bus.pwr_state, bus.alu_pwr_en, bus.iso_en, bus.alu_ready); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pwr_state !== 3'd3) begin errors++; $display("FAIL rmid_pend_cleared: got %0d expected 3", bus.pwr_state); end
    cyc(0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    checks++; if (bus.pwr_state !== 3'd4) begin errors++; $display("FAIL rmid_ramp: got %0d expected 4", bus.pwr_state); end
    rst_cyc();
    checks++; if ({bus.pwr_state, bus.alu_pwr_en, bus.iso_en} !== {3'd3, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rmid_ramp_rst: got st=%0d pwr=%0b iso=%0b expected 3 0 1", bus.pwr_state, bus.alu_pwr_en, bus.iso_en); end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    bit prev_pwr = bus.alu_pwr_en;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst_cyc();
      else cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
      got = {bus.pwr_state, bus.alu_pwr_en, bus.iso_en, bus.alu_ready, bus.start_o, bus.start_drop};
      exp = {3'(m_ph), pwr_tab[m_ph], iso_tab[m_ph], ready_tab[m_ph], m_so, m_drop};
      checks++; if (got !== exp) begin
        errors++; $display("FAIL random_cycle %0d: got %b expected %b (state,pwr,iso,ready,start_o,drop)", i, got, exp); end
      checks++; if (bus.iso_en !== 1'b1 && (bus.alu_pwr_en !== 1'b1 || bus.alu_pwr_en !== prev_pwr)) begin
        errors++; $display("FAIL iso_invariant %0d: got iso=%0b pwr=%0b prev_pwr=%0b expected iso=1", i, bus.iso_en, bus.alu_pwr_en, prev_pwr); end
      prev_pwr = bus.alu_pwr_en;
    end
  endtask

  initial begin
    bus.sleep_req = 0; bus.wake_req = 0; bus.start_i = 0; bus.alu_busy = 0;
    model_reset();
    test_reset();
    test_wake();
    test_sleep_drain();
    test_idle();
    test_off_start();
    test_wake_iso();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
